// File: rtl/keypad_event_scanner_pkg.sv
// Shared definitions for the matrix keypad event scanner.
// Walk FSM encodings, event field layout and debounce counter width.
package keypad_event_scanner_pkg;

  localparam logic IDLE = 1'b0;
  localparam logic WALK = 1'b1;

  localparam int CODE_LSB = 0;
  localparam int DB_W = 4;

  function automatic int code_w(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

endpackage

// File: rtl/keypad_event_scanner_fifo.sv
// First-word-fall-through event queue for the keypad scanner.
// A push into a full queue is accepted only when a pop frees a slot.
module event_fifo
  import keypad_event_scanner_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = count != '0;
  assign full    = count == CNT_W'(DEPTH);
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_event_scanner.sv
// Matrix keypad scanner: column drive, row sync, per-key debounce,
// and a press/release event queue with valid/ready read port.
module keypad_event_scanner
  import keypad_event_scanner_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 300_000,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 8,
  localparam int CODE_W    = code_w(ROWS, COLS),
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_l,
  output logic [COLS-1:0]      col,
  input  logic [ROWS-1:0]      row,
  output logic                 scan,
  output logic [ROWS*COLS-1:0] keys,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [CODE_W:0]      evt_data,
  output logic [CNT_W-1:0]     evt_count,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  localparam int NKEY      = ROWS * COLS;
  localparam int DIV_W     = $clog2(SCAN_DIV);
  localparam int COL_W     = $clog2(COLS);
  localparam int ROW_W     = $clog2(ROWS);
  localparam int PRESS_BIT = CODE_W;

  logic [DIV_W-1:0]  div_cnt;
  logic [COL_W-1:0]  col_idx;
  logic [COL_W-1:0]  walk_col;
  logic [ROW_W-1:0]  walk_row;
  logic [ROWS-1:0]   row_s1;
  logic [ROWS-1:0]   row_s2;
  logic [ROWS-1:0]   samp;
  logic              state;
  logic [DB_W-1:0]   cnt [NKEY];
  logic              push_q;
  logic [CODE_W:0]   push_data;
  logic              fifo_full;
  logic              pop;
  logic              drop;
  logic [CODE_W-1:0] k;
  logic              hit;

  assign scan = div_cnt == DIV_W'(SCAN_DIV - 1);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign col[c] = (col_idx == COL_W'(c)) ? 1'b0 : 1'bz;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      div_cnt  <= '0;
      col_idx  <= '0;
      walk_col <= '0;
      samp     <= '1;
    end else if (scan) begin
      div_cnt  <= '0;
      samp     <= row_s2;
      walk_col <= col_idx;
      if (col_idx == COL_W'(COLS - 1)) col_idx <= '0;
      else col_idx <= col_idx + COL_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  // rows are active-low; invert so the debouncer works in pressed=1 terms
  assign k   = CODE_W'(walk_row) * CODE_W'(COLS) + CODE_W'(walk_col);
  assign hit = ~samp[walk_row];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      walk_row  <= '0;
      keys      <= '0;
      push_q    <= 1'b0;
      push_data <= '0;
      for (int i = 0; i < NKEY; i++) cnt[i] <= '0;
    end else begin
      push_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (scan) begin
            state    <= WALK;
            walk_row <= '0;
          end
        end
        WALK: begin
          if (hit == keys[k]) begin
            cnt[k] <= '0;
          end else if (cnt[k] == DB_W'(DEBOUNCE - 1)) begin
            cnt[k]                          <= '0;
            keys[k]                         <= hit;
            push_q                          <= 1'b1;
            push_data[PRESS_BIT]            <= hit;
            push_data[CODE_LSB +: CODE_W]   <= k;
          end else begin
            cnt[k] <= cnt[k] + DB_W'(1);
          end
          if (walk_row == ROW_W'(ROWS - 1)) state <= IDLE;
          else walk_row <= walk_row + ROW_W'(1);
        end
      endcase
    end
  end

  assign pop  = evt_valid && evt_ready;
  assign drop = push_q && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  event_fifo #(
    .WIDTH(CODE_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_l(rst_l),
    .push (push_q),
    .din  (push_data),
    .pop  (pop),
    .dout (evt_data),
    .valid(evt_valid),
    .count(evt_count),
    .full (fifo_full)
  );

endmodule
